// File: rtl/act_feed_pkg.sv
// Shared encodings and field layout for the ACT feeder.
package act_feed_pkg;

  // ACT op_type encodings
  typedef enum logic [1:0] {
    OP_ACT    = 2'd0,
    OP_BIAS   = 2'd1,
    OP_WSCALE = 2'd2,
    OP_ASCALE = 2'd3
  } op_e;

  // Feeder sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG_B = 3'd1,
    CFG_W = 3'd2,
    CFG_A = 3'd3,
    DRAIN = 3'd4
  } state_e;

  localparam int unsigned BIAS_W   = 16;
  localparam int unsigned MANT_W   = 10;
  localparam int unsigned EXP_W    = 6;
  localparam int unsigned MANT_LSB = 0;
  localparam int unsigned EXP_LSB  = 16;

endpackage

// File: rtl/act_feeder_if.sv
// Host/array-facing bus of the ACT feeder plus its ACT-side outputs.
interface act_feeder_if
  import act_feed_pkg::*;
#(
  parameter int unsigned COLS   = 8,
  parameter int unsigned PSUM_W = 32
);
  localparam int unsigned COL_W = $clog2(COLS);

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [BIAS_W-1:0]      cfg_bias;
  logic [MANT_W-1:0]      cfg_w_m;
  logic [EXP_W-1:0]       cfg_w_e;
  logic [MANT_W-1:0]      cfg_a_m;
  logic [EXP_W-1:0]       cfg_a_e;
  logic                   psum_valid;
  logic                   psum_ready;
  logic [COLS*PSUM_W-1:0] psum_in;
  logic [1:0]             op_type;
  logic [PSUM_W-1:0]      data_out;
  logic                   res_vld;
  logic [COL_W-1:0]       res_col;
  logic                   busy;

  modport master (
    output cfg_valid, cfg_bias, cfg_w_m, cfg_w_e, cfg_a_m, cfg_a_e,
    output psum_valid, psum_in,
    input  cfg_ready, psum_ready, op_type, data_out, res_vld, res_col, busy
  );

  modport slave (
    input  cfg_valid, cfg_bias, cfg_w_m, cfg_w_e, cfg_a_m, cfg_a_e,
    input  psum_valid, psum_in,
    output cfg_ready, psum_ready, op_type, data_out, res_vld, res_col, busy
  );
endinterface

// File: rtl/psum_row_fifo.sv
// Small row buffer; head is visible combinationally.
module psum_row_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         one_left
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign one_left = (count == CNT_W'(1));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head     = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Row storage (contents need no reset)
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/act_feeder.sv
// Buffers psum rows, serialises them onto the ACT interface, and sequences ACT config writes.
module act_feeder
  import act_feed_pkg::*;
#(
  parameter int unsigned COLS       = 8,
  parameter int unsigned PSUM_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic        clk,
  input logic        rst_n,
  act_feeder_if.slave bus
);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = COLS * PSUM_W;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  op_e               op_q, op_d;
  logic [PSUM_W-1:0] data_q, data_d;
  logic              act_vld_q, act_vld_d;
  logic [COL_W-1:0]  bus_col_q, bus_col_d;
  logic              res_vld_q;
  logic [COL_W-1:0]  res_col_q;
  logic [PSUM_W-1:0] w_word_q, a_word_q;
  logic [PSUM_W-1:0] w_word_c, a_word_c;

  logic [ROW_W-1:0]  head;
  logic [PSUM_W-1:0] head_cols [COLS];
  logic              full, empty, one_left;
  logic              push, pop;
  logic              cfg_acc;

  assign bus.cfg_ready  = (state_q == IDLE) && empty;
  assign bus.psum_ready = !full;
  assign bus.busy       = (state_q != IDLE) || !empty;
  assign bus.op_type    = op_q;
  assign bus.data_out   = data_q;
  assign bus.res_vld    = res_vld_q;
  assign bus.res_col    = res_col_q;

  assign push    = bus.psum_valid && !full;
  assign cfg_acc = bus.cfg_valid && bus.cfg_ready;

  psum_row_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ROW_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .din      (bus.psum_in),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .one_left (one_left)
  );

  // Split the head row into per-column words
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      head_cols[c] = head[c*PSUM_W +: PSUM_W];
    end
  end

  // Assemble scale config words from the live cfg inputs
  always_comb begin
    w_word_c = '0;
    a_word_c = '0;
    w_word_c[MANT_LSB +: MANT_W] = bus.cfg_w_m;
    w_word_c[EXP_LSB  +: EXP_W]  = bus.cfg_w_e;
    a_word_c[MANT_LSB +: MANT_W] = bus.cfg_a_m;
    a_word_c[EXP_LSB  +: EXP_W]  = bus.cfg_a_e;
  end

  // Next-state and next ACT word; the word decided here is on the bus next cycle
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    op_d      = OP_ACT;
    data_d    = '0;
    act_vld_d = 1'b0;
    bus_col_d = '0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_acc) begin
          op_d    = OP_BIAS;
          data_d  = PSUM_W'($signed(bus.cfg_bias));
          state_d = CFG_B;
        end else if (!empty) begin
          data_d    = head_cols[0];
          act_vld_d = 1'b1;
          col_d     = COL_W'(1);
          state_d   = DRAIN;
        end
      end
      CFG_B: begin
        op_d    = OP_WSCALE;
        data_d  = w_word_q;
        state_d = CFG_W;
      end
      CFG_W: begin
        op_d    = OP_ASCALE;
        data_d  = a_word_q;
        state_d = CFG_A;
      end
      CFG_A: begin
        // A row that arrived with the config starts right behind op3
        if (!empty) begin
          data_d    = head_cols[0];
          act_vld_d = 1'b1;
          col_d     = COL_W'(1);
          state_d   = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        data_d    = head_cols[col_q];
        act_vld_d = 1'b1;
        bus_col_d = col_q;
        if (col_q == COL_W'(COLS - 1)) begin
          pop   = 1'b1;
          col_d = '0;
          if (!one_left || push) state_d = DRAIN;
          else                   state_d = IDLE;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, ACT output and result-tag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      op_q      <= OP_ACT;
      data_q    <= '0;
      act_vld_q <= 1'b0;
      bus_col_q <= '0;
      res_vld_q <= 1'b0;
      res_col_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      op_q      <= op_d;
      data_q    <= data_d;
      act_vld_q <= act_vld_d;
      bus_col_q <= bus_col_d;
      res_vld_q <= act_vld_q;
      res_col_q <= bus_col_q;
    end
  end

  // Capture scale words at config acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_word_q <= '0;
      a_word_q <= '0;
    end else if (cfg_acc) begin
      w_word_q <= w_word_c;
      a_word_q <= a_word_c;
    end
  end
endmodule

// File: tb/tb_act_feeder.sv
// Directed bench for act_feeder.
module tb_act_feeder;
  localparam int unsigned COLS   = 8;
  localparam int unsigned PSUM_W = 32;
  localparam int unsigned ROW_W  = COLS * PSUM_W;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  act_feeder_if #(.COLS(COLS), .PSUM_W(PSUM_W)) bus ();

  act_feeder #(.COLS(COLS), .PSUM_W(PSUM_W), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] mk_row(input int base, input int step);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int c = 0; c < COLS; c++) r[c*PSUM_W +: PSUM_W] = 32'(base + c * step);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst_n = 1'b1;
      tick();
      n_cmp++;
      if (bus.res_vld !== 1'b0 || bus.op_type !== 2'd0 || bus.data_out !== 32'h0) begin
        n_err++;
        $display("FAIL reset_outputs cyc%0d: res_vld=%b op=%0d data=%h, want 0/0/0", i, bus.res_vld, bus.op_type, bus.data_out);
      end
      n_cmp++;
      if (bus.cfg_ready !== 1'b1 || bus.psum_ready !== 1'b1 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_flags cyc%0d: cfg_ready=%b psum_ready=%b busy=%b, want 1/1/0", i, bus.cfg_ready, bus.psum_ready, bus.busy);
      end
    end
  endtask

  task automatic test_config();
    logic [1:0]  exp_op [4];
    logic [31:0] exp_d  [4];
    exp_op[0] = 2'd1; exp_d[0] = 32'hFFFF_FFFB;
    exp_op[1] = 2'd2; exp_d[1] = 32'h003E_0003;
    exp_op[2] = 2'd3; exp_d[2] = 32'h0001_0007;
    exp_op[3] = 2'd0; exp_d[3] = 32'h0;
    bus.cfg_valid = 1'b1;
    bus.cfg_bias  = 16'hFFFB;
    bus.cfg_w_m   = 10'd3;
    bus.cfg_w_e   = 6'h3E;
    bus.cfg_a_m   = 10'd7;
    bus.cfg_a_e   = 6'd1;
    n_cmp++;
    if (bus.cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cfg_ready_idle: got %b want 1", bus.cfg_ready);
    end
    tick();
    bus.cfg_valid = 1'b0;
    bus.cfg_bias  = '0;
    bus.cfg_w_m   = '0;
    bus.cfg_w_e   = '0;
    bus.cfg_a_m   = '0;
    bus.cfg_a_e   = '0;
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (bus.op_type !== exp_op[j] || bus.data_out !== exp_d[j] || bus.res_vld !== 1'b0) begin
        n_err++;
        $display("FAIL cfg_word t+%0d: op=%0d data=%h res_vld=%b, want op=%0d data=%h res_vld=0",
                 j + 1, bus.op_type, bus.data_out, bus.res_vld, exp_op[j], exp_d[j]);
      end
      if (j < 3) tick();
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cfg_back_idle: busy=%b cfg_ready=%b, want 0/1", bus.busy, bus.cfg_ready);
    end
  endtask

  task automatic test_single_row();
    logic [31:0] exp_d;
    logic        exp_v;
    bus.psum_valid = 1'b1;
    bus.psum_in    = mk_row(1, 10);
    tick();
    bus.psum_valid = 1'b0;
    bus.psum_in    = '0;
    for (int j = 1; j <= 11; j++) begin
      exp_d = (j >= 2 && j <= 9) ? 32'((j - 2) * 10 + 1) : 32'h0;
      exp_v = (j >= 3 && j <= 10);
      n_cmp++;
      if (bus.op_type !== 2'd0 || bus.data_out !== exp_d) begin
        n_err++;
        $display("FAIL row_data t+%0d: op=%0d data=%h, want op=0 data=%h", j, bus.op_type, bus.data_out, exp_d);
      end
      n_cmp++;
      if (bus.res_vld !== exp_v || (exp_v && bus.res_col !== 3'(j - 3))) begin
        n_err++;
        $display("FAIL row_tag t+%0d: res_vld=%b res_col=%0d, want res_vld=%b res_col=%0d", j, bus.res_vld, bus.res_col, exp_v, j - 3);
      end
      if (j < 11) tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    int          next_row;
    int          idx;
    bit          saw_full;
    bit          acc;
    next_row = 0;
    idx      = 0;
    saw_full = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < COLS; c++) exp_q.push_back(32'(32'h1000 * (r + 1) + c + 1));
    for (int cyc = 0; cyc < 60; cyc++) begin
      acc = 1'b0;
      if (next_row < 3) begin
        bus.psum_valid = 1'b1;
        bus.psum_in    = mk_row(32'h1000 * (next_row + 1) + 1, 1);
        acc            = bus.psum_ready;
        if (!bus.psum_ready) saw_full = 1'b1;
      end else begin
        bus.psum_valid = 1'b0;
        bus.psum_in    = '0;
      end
      tick();
      if (acc) next_row++;
      if (idx < 24 && (idx > 0 || bus.data_out !== 32'h0)) begin
        n_cmp++;
        if (bus.op_type !== 2'd0 || bus.data_out !== exp_q[idx]) begin
          n_err++;
          $display("FAIL b2b_word%0d: op=%0d data=%h, want op=0 data=%h", idx, bus.op_type, bus.data_out, exp_q[idx]);
        end
        idx++;
      end
    end
    bus.psum_valid = 1'b0;
    n_cmp++;
    if (idx != 24 || next_row != 3) begin
      n_err++;
      $display("FAIL b2b_count: words=%0d rows=%0d, want 24/3", idx, next_row);
    end
    n_cmp++;
    if (!saw_full) begin
      n_err++;
      $display("FAIL b2b_backpressure: psum_ready never low, want low while full");
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_cfg_and_row();
    logic [1:0]  exp_op;
    logic [31:0] exp_d;
    logic        exp_v;
    bus.cfg_valid  = 1'b1;
    bus.cfg_bias   = 16'd100;
    bus.cfg_w_m    = 10'd5;
    bus.cfg_w_e    = 6'd3;
    bus.cfg_a_m    = 10'd9;
    bus.cfg_a_e    = 6'h3F;
    bus.psum_valid = 1'b1;
    bus.psum_in    = mk_row(32'h200, 1);
    n_cmp++;
    if (bus.cfg_ready !== 1'b1 || bus.psum_ready !== 1'b1) begin
      n_err++;
      $display("FAIL both_ready: cfg_ready=%b psum_ready=%b, want 1/1", bus.cfg_ready, bus.psum_ready);
    end
    tick();
    bus.cfg_valid  = 1'b0;
    bus.psum_valid = 1'b0;
    bus.psum_in    = '0;
    for (int j = 1; j <= 12; j++) begin
      case (j)
        1:       begin exp_op = 2'd1; exp_d = 32'd100;      end
        2:       begin exp_op = 2'd2; exp_d = 32'h0003_0005; end
        3:       begin exp_op = 2'd3; exp_d = 32'h003F_0009; end
        12:      begin exp_op = 2'd0; exp_d = 32'h0;        end
        default: begin exp_op = 2'd0; exp_d = 32'(32'h200 + j - 4); end
      endcase
      exp_v = (j >= 5);
      n_cmp++;
      if (bus.op_type !== exp_op || bus.data_out !== exp_d || bus.res_vld !== exp_v) begin
        n_err++;
        $display("FAIL cfg_row t+%0d: op=%0d data=%h res_vld=%b, want op=%0d data=%h res_vld=%b",
                 j, bus.op_type, bus.data_out, bus.res_vld, exp_op, exp_d, exp_v);
      end
      if (j < 12) tick();
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] exp_d;
    logic        exp_v;
    bus.psum_valid = 1'b1;
    bus.psum_in    = mk_row(32'h301, 1);
    tick();
    bus.psum_valid = 1'b1;
    bus.psum_in    = mk_row(32'h401, 1);
    tick();
    bus.psum_valid = 1'b0;
    bus.psum_in    = '0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (bus.data_out !== 32'h304 || bus.op_type !== 2'd0) begin
      n_err++;
      $display("FAIL mid_col3: op=%0d data=%h, want op=0 data=00000304", bus.op_type, bus.data_out);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (bus.res_vld !== 1'b0 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1 ||
        bus.psum_ready !== 1'b1 || bus.data_out !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset: res_vld=%b busy=%b cfg_ready=%b psum_ready=%b data=%h, want 0/0/1/1/0",
               bus.res_vld, bus.busy, bus.cfg_ready, bus.psum_ready, bus.data_out);
    end
    bus.psum_valid = 1'b1;
    bus.psum_in    = mk_row(32'h501, 1);
    tick();
    bus.psum_valid = 1'b0;
    bus.psum_in    = '0;
    for (int j = 1; j <= 10; j++) begin
      exp_d = (j >= 2 && j <= 9) ? 32'(32'h501 + j - 2) : 32'h0;
      exp_v = (j >= 3 && j <= 10);
      n_cmp++;
      if (bus.data_out !== exp_d || bus.res_vld !== exp_v || (exp_v && bus.res_col !== 3'(j - 3))) begin
        n_err++;
        $display("FAIL post_reset t+%0d: data=%h res_vld=%b res_col=%0d, want data=%h res_vld=%b res_col=%0d",
                 j, bus.data_out, bus.res_vld, bus.res_col, exp_d, exp_v, j - 3);
      end
      if (j < 10) tick();
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_bias   = '0;
    bus.cfg_w_m    = '0;
    bus.cfg_w_e    = '0;
    bus.cfg_a_m    = '0;
    bus.cfg_a_e    = '0;
    bus.psum_valid = 1'b0;
    bus.psum_in    = '0;
    test_reset();
    test_config();
    tick();
    test_single_row();
    tick();
    test_back_to_back();
    tick();
    test_cfg_and_row();
    tick();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/act_feeder.md
Name: act_feeder

Overview:
- Upstream neighbour of the ACT requant/activation stage.
- Accepts full rows of COLS parallel 32-bit partial sums drained from the systolic array bottom edge and buffers them.
- Serialises each row one column per cycle onto the ACT op_type/data_in interface as op 0.
- Also sequences the three ACT configuration writes (bias, weight scale, activation scale), and tags each ACT result with its column index.

Parameters:
- COLS, 8, psums per row; must be a power of two, at least 2.
- PSUM_W, 32, width of one psum and of the ACT data word.
- FIFO_DEPTH, 2, row-buffer entries.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted when high with cfg_valid
- cfg_bias  in  16  signed bias
- cfg_w_m  in  10  weight-scale mantissa
- cfg_w_e  in  6  signed weight-scale exponent
- cfg_a_m  in  10  activation-scale mantissa
- cfg_a_e  in  6  signed activation-scale exponent
- psum_valid  in  1  row valid
- psum_ready  out  1  row accepted when high with psum_valid
- psum_in  in  COLS*PSUM_W  row; column c is at bits [c*PSUM_W +: PSUM_W]
- op_type  out  2  to ACT
- data_out  out  PSUM_W  to ACT data_in
- res_vld  out  1  ACT data_act holds a valid result this cycle
- res_col  out  log2(COLS)  column of that result
- busy  out  1  state not IDLE, or FIFO not empty

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is synchronous, active-low.
- Reset values:
  - state IDLE; FIFO empty; column counter 0.
  - op_type=0, data_out=0, res_vld=0, res_col=0.
  - cfg_ready=1, psum_ready=1, busy=0.
- Reset mid-row or mid-config discards all buffered rows and any pending sequence. The feeder holds no config copy; the host reissues cfg after reset.
- op_type and data_out are driven from flops.
- Idle/filler cycles drive op_type=0 and data_out=0 with no valid tag. ACT overwrites data_act on these cycles, which is harmless because consumers qualify on res_vld.
- FSM states: IDLE, CFG_B, CFG_W, CFG_A, DRAIN.
- Handshakes:
  - cfg_ready = (state==IDLE) and FIFO empty.
  - psum_ready = FIFO not full, in any state.
  - A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- IDLE, config accepted:
  - IDLE -> CFG_B -> CFG_W -> CFG_A -> IDLE, one cycle each.
  - Config accepted in cycle t gives: op1 at t+1, op2 at t+2, op3 at t+3.
  - Config fields are captured at acceptance.
- Config word formats:
  - op1: data_out = sign-extended cfg_bias.
  - op2: data_out[9:0]=cfg_w_m, [21:16]=cfg_w_e, all other bits 0.
  - op3: data_out[9:0]=cfg_a_m, [21:16]=cfg_a_e, all other bits 0.
- Simultaneous config and row acceptance in IDLE: both are accepted. The row is pushed, the config sequence runs first, and the row drains with the new config; first op0 at t+4.
- IDLE with FIFO non-empty and no config accepted: enter DRAIN with col=0.
- Latency from IDLE with an empty FIFO: a row accepted in cycle t puts column k on the ACT interface in cycle t+2+k.
- DRAIN:
  - Each cycle issue op0 with data_out = column col of the FIFO head; col increments.
  - At col==COLS-1: pop the head and wrap col to 0.
  - If a row remains after the pop, including one pushed in the same cycle, continue in DRAIN with no bubble. Otherwise go to IDLE.
- Result tagging: res_vld and res_col are op0-issue-valid and col delayed by one cycle, matching ACT's one-cycle register. They are asserted in cycle t+3+k.
- Config words never assert res_vld.
- Throughput: one row per COLS cycles sustained.

Decomposition:
- Package act_feed_pkg holds:
  - op_type encodings OP_ACT=0, OP_BIAS=1, OP_WSCALE=2, OP_ASCALE=3;
  - the FSM state enum;
  - the field offsets (mantissa lsb 0, exponent lsb 16).
- Sub-module psum_row_fifo: parameterised FIFO_DEPTH x COLS*PSUM_W, synchronous active-low reset, push/pop/full/empty, head output available combinationally.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> res_vld=0, op_type=0, data_out=0, cfg_ready=1, psum_ready=1, busy=0 throughout.
- Config: bias=-5, w_m=3, w_e=-2, a_m=7, a_e=1 accepted at t -> exactly the following, then IDLE:
  - t+1: op1, 0xFFFFFFFB
  - t+2: op2, 0x003E0003
  - t+3: op3, 0x00010007
- Single row, columns c*10+1, accepted at t -> op0 with data 1, 11, … 71 in cycles t+2…t+9; res_vld in cycles t+3…t+10 with res_col 0…7.
- Back-to-back: three rows offered continuously -> 24 consecutive op0 cycles with no gap; psum_ready drops while the FIFO is full; rows drain in order.
- Simultaneous config and row in IDLE -> op1/op2/op3 first, then 8 op0 words; res_vld never set during config.
- Reset asserted mid-row at column 3 -> next cycle: FIFO empty, res_vld=0, state IDLE; a new row then starts at column 0.
